universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised successor to the 4-mode shift register. It is an N-bit register with parallel load, logical, arithmetic and rotate shifts, serial in/out, and a multi-cycle rotate sequencer with a busy/done handshake. It sits in the shift_register testcase family and is compared cycle-by-cycle against its post-route netlist by the standard golden-vs-netlist bench.

## Interface
- N, default 8: register width, N >= 2.
- AW, default $clog2(N)+1 (derived, not overridden): width of amt; the range 0..2N-1 is legal.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ctrl  in  3  opcode, sampled only when busy=0.
  - 0 hold
  - 1 shr logical
  - 2 shl logical
  - 3 parallel load
  - 4 rotr
  - 5 rotl
  - 6 shr arithmetic
  - 7 start sequence
- data  in  N  parallel load value (ctrl=3).
- ser_in  in  1  fill bit for logical shifts.
- amt  in  AW  step count for sequence, captured at ctrl=7.
- dir  in  1  sequence direction, captured at ctrl=7: 0 = rotr, 1 = rotl.
- q_reg  out  N  register contents.
- ser_out  out  1  registered bit most recently shifted out.
- busy  out  1  high while the sequence is running (RUN state).
- done  out  1  one-cycle pulse when the sequence completes.

## Operation
Opcodes, applied at the clock edge when busy=0:
- 0: q_reg unchanged, ser_out unchanged.
- 1: q_reg <= {ser_in, q_reg[N-1:1]}; ser_out <= q_reg[0].
- 2: q_reg <= {q_reg[N-2:0], ser_in}; ser_out <= q_reg[N-1].
- 3: q_reg <= data; ser_out unchanged.
- 4 / 5: rotate right / left by 1; ser_out unchanged.
- 6: q_reg <= {q_reg[N-1], q_reg[N-1:1]}; ser_out <= q_reg[0].
- 7: capture amt into counter cnt and dir into a direction register; q_reg unchanged on this edge.

FSM states: IDLE, RUN, DONE.
- IDLE, ctrl=7, amt!=0 -> RUN.
- IDLE, ctrl=7, amt=0 -> DONE.
- IDLE, any other ctrl -> execute the opcode and stay in IDLE.
- RUN: every cycle, rotate q_reg by 1 in the captured direction and decrement cnt. When a step is taken with cnt==1, go to DONE. ctrl, data, amt and dir are ignored.
- DONE: done=1. The opcode is accepted exactly as in IDLE, so a new ctrl=7 re-enters RUN or DONE with no bubble; any other opcode goes to IDLE.

Output rules:
- busy = (state==RUN); done = (state==DONE). Both come straight from state registers, with no combinational path from inputs.
- Counter arithmetic is unsigned, AW bits; cnt never underflows.
- amt = N leaves q_reg equal to its original value; amt = N+k is equivalent to k rotations (no modulo is applied, all steps are executed).

## Timing
- Reset values: q_reg=0, ser_out=0, busy=0, done=0, state=IDLE, cnt=0.
- Reset is asynchronous. Assertion mid-sequence aborts immediately: q_reg=0, no done pulse.
- Single-cycle opcodes: the result is visible after the sampling edge (latency 1).
- Sequence with ctrl=7 sampled at edge k and amt=A>0:
  - busy high from after edge k until after edge k+A.
  - q_reg rotates at edges k+1..k+A.
  - done high for exactly the cycle after edge k+A.
- amt=0: done high for the cycle after edge k; busy never rises; q_reg unchanged.
- While busy=1, ctrl, data, ser_in, amt and dir are don't-care. The bench may drive anything on them with no effect.

## Test plan
(All with N=8.)
1. Reset: reset=1 for 20 cycles -> q_reg=0, ser_out=0, busy=0, done=0. Re-assert reset between edges after loading 0xFF -> q_reg=0 before the next edge.
2. Logical shifts:
   - load 0x55, ctrl=1, ser_in=1 -> q_reg=0xAA, ser_out=1.
   - then ctrl=2, ser_in=0 -> q_reg=0x54, ser_out=1.
   - ctrl=0 for 10 cycles -> q_reg stays 0x54.
3. Arithmetic and rotate, each from a fresh load of 0x81:
   - ctrl=6 -> 0xC0, ser_out=1.
   - ctrl=4 -> 0xC0, ser_out unchanged.
   - ctrl=5 -> 0x03.
4. Sequence: load 0x01, ctrl=7, amt=3, dir=1 -> busy for 3 cycles, q_reg 0x02, 0x04, 0x08, then done=1 for 1 cycle. A ctrl=3 with data=0xFF driven while busy is ignored (final q_reg=0x08).
5. Sequence edge cases:
   - load 0xA5, amt=0 -> done next cycle, busy never high, q_reg=0xA5.
   - amt=8, dir=0 -> q_reg=0xA5 after 8 steps.
   - ctrl=7 issued during DONE starts the next sequence with no idle cycle.
6. Abort and regression:
   - reset asserted after the 2nd step of an amt=5 sequence -> q_reg=0, busy=0, no done.
   - then 100 random ctrl (0-6) / data / ser_in vectors -> golden q_reg/ser_out match the netlist with zero mismatches.

Source files
------------

// File: rtl/universal_shift_register_if.sv
// Bus bundle for the universal shift register: opcode/data inputs driven by the
// controlling side, register contents and sequencer handshake returned by the
// shift register.
interface universal_shift_register_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N) + 1;

  logic [2:0]    ctrl;
  logic [N-1:0]  data;
  logic          ser_in;
  logic [AW-1:0] amt;
  logic          dir;
  logic [N-1:0]  q_reg;
  logic          ser_out;
  logic          busy;
  logic          done;

  modport master (
    output ctrl, data, ser_in, amt, dir,
    input  q_reg, ser_out, busy, done
  );

  modport slave (
    input  ctrl, data, ser_in, amt, dir,
    output q_reg, ser_out, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: parallel load, logical/arithmetic shifts,
// single-step rotates and a multi-cycle rotate sequencer (IDLE/RUN/DONE) with
// busy/done handshake. busy and done are decoded purely from the state register.
module universal_shift_register #(
  parameter int N = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  universal_shift_register_if.slave   bus
);
  localparam int AW = $clog2(N) + 1;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;
  localparam logic [2:0] OP_ROTL = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_SEQ  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          ser_q, ser_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  // One-step rotations of the current contents, shared by opcodes 4/5 and RUN.
  logic [N-1:0]  rotr_w, rotl_w;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_rot
      assign rotr_w[gi] = q_q[(gi + 1) % N];
      assign rotl_w[gi] = q_q[(gi + N - 1) % N];
    end
  endgenerate

  // State register; reset aborts any sequence at once without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      ser_q   <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: RUN ignores the bus; IDLE and DONE both accept an opcode.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    if (state_q == RUN) begin
      q_d = dir_q ? rotl_w : rotr_w;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - AW'(1);
      end
      // cnt==0 cannot occur in RUN; treating it as the last step avoids a lock-up.
      if (cnt_q <= AW'(1)) begin
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
      case (bus.ctrl)
        OP_HOLD: ;
        OP_SHR: begin
          q_d   = {bus.ser_in, q_q[N-1:1]};
          ser_d = q_q[0];
        end
        OP_SHL: begin
          q_d   = {q_q[N-2:0], bus.ser_in};
          ser_d = q_q[N-1];
        end
        OP_LOAD: q_d = bus.data;
        OP_ROTR: q_d = rotr_w;
        OP_ROTL: q_d = rotl_w;
        OP_ASR: begin
          q_d   = {q_q[N-1], q_q[N-1:1]};
          ser_d = q_q[0];
        end
        OP_SEQ: begin
          cnt_d   = bus.amt;
          dir_d   = bus.dir;
          state_d = (bus.amt != '0) ? RUN : DONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.q_reg   = q_q;
  assign bus.ser_out = ser_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N=8): directed scenarios
// with constant expectations plus a random single-cycle-opcode regression
// against a small behavioural model, all through a scoreboard queue.
module tb_universal_shift_register;
  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic clk;
  logic reset;

  universal_shift_register_if #(.N(N)) bus ();

  universal_shift_register #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [N-1:0] q;
    logic         ser;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model for the random regression.
  logic [N-1:0] m_q;
  logic         m_ser;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic compare_next();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".q"},    32'(bus.q_reg),   32'(e.q));
    check_val({e.tag, ".ser"},  32'(bus.ser_out), 32'(e.ser));
    check_val({e.tag, ".busy"}, 32'(bus.busy),    32'(e.busy));
    check_val({e.tag, ".done"}, 32'(bus.done),    32'(e.done));
    $display("txn %-10s ctrl=%0d q=0x%02h ser=%0b busy=%0b done=%0b", e.tag, bus.ctrl,
             bus.q_reg, bus.ser_out, bus.busy, bus.done);
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, check it.
  task automatic step(input logic [2:0] c, input logic [N-1:0] d, input logic s,
                      input logic [AW-1:0] a, input logic di, input string tag,
                      input logic [N-1:0] eq, input logic es, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    bus.ctrl   = c;
    bus.data   = d;
    bus.ser_in = s;
    bus.amt    = a;
    bus.dir    = di;
    e.tag = tag; e.q = eq; e.ser = es; e.busy = eb; e.done = ed;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  task automatic check_idle_reset(input string tag);
    check_val({tag, ".q"},    32'(bus.q_reg),   32'd0);
    check_val({tag, ".ser"},  32'(bus.ser_out), 32'd0);
    check_val({tag, ".busy"}, 32'(bus.busy),    32'd0);
    check_val({tag, ".done"}, 32'(bus.done),    32'd0);
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] seq8 [8];
    logic [2:0]   rc;
    logic [N-1:0] rd;
    logic         rs;
    logic [N-1:0] nq;
    logic         nser;
    seq8 = '{8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96, 8'h4B, 8'hA5};

    bus.ctrl = 3'd0; bus.data = '0; bus.ser_in = 1'b0; bus.amt = '0; bus.dir = 1'b0;

    // 1. Reset held for 20 cycles, then asynchronous reset between edges.
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_idle_reset("reset20");
    @(negedge clk);
    reset = 1'b0;
    step(3'd3, 8'hFF, 1'b0, '0, 1'b0, "load_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 check_idle_reset("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // 2. Logical shifts and hold.
    step(3'd3, 8'h55, 1'b0, '0, 1'b0, "load_55", 8'h55, 1'b0, 1'b0, 1'b0);
    step(3'd1, 8'h00, 1'b1, '0, 1'b0, "shr",     8'hAA, 1'b1, 1'b0, 1'b0);
    step(3'd2, 8'h00, 1'b0, '0, 1'b0, "shl",     8'h54, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(3'd0, 8'hC3, 1'b1, '1, 1'b1, "hold", 8'h54, 1'b1, 1'b0, 1'b0);

    // 3. Arithmetic shift and single rotates from fresh loads of 0x81.
    step(3'd3, 8'h81, 1'b0, '0, 1'b0, "load_81", 8'h81, 1'b1, 1'b0, 1'b0);
    step(3'd6, 8'h00, 1'b0, '0, 1'b0, "asr",     8'hC0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 8'h00, 1'b0, '0, 1'b0, "shr0",    8'h60, 1'b0, 1'b0, 1'b0);
    step(3'd3, 8'h81, 1'b0, '0, 1'b0, "load_81", 8'h81, 1'b0, 1'b0, 1'b0);
    step(3'd4, 8'h00, 1'b1, '0, 1'b0, "rotr",    8'hC0, 1'b0, 1'b0, 1'b0);
    step(3'd3, 8'h81, 1'b0, '0, 1'b0, "load_81", 8'h81, 1'b0, 1'b0, 1'b0);
    step(3'd5, 8'h00, 1'b1, '0, 1'b0, "rotl",    8'h03, 1'b0, 1'b0, 1'b0);

    // 4. Sequence amt=3 rotl; a load attempted while busy must be ignored.
    step(3'd3, 8'h01, 1'b0, '0,    1'b0, "load_01",  8'h01, 1'b0, 1'b0, 1'b0);
    step(3'd7, 8'h00, 1'b0, 4'd3,  1'b1, "seq3",     8'h01, 1'b0, 1'b1, 1'b0);
    step(3'd3, 8'hFF, 1'b1, 4'd9,  1'b0, "seq3_s1",  8'h02, 1'b0, 1'b1, 1'b0);
    step(3'd3, 8'hFF, 1'b1, 4'd9,  1'b0, "seq3_s2",  8'h04, 1'b0, 1'b1, 1'b0);
    step(3'd3, 8'hFF, 1'b1, 4'd9,  1'b0, "seq3_s3",  8'h08, 1'b0, 1'b0, 1'b1);
    step(3'd0, 8'hFF, 1'b0, '0,    1'b0, "seq3_end", 8'h08, 1'b0, 1'b0, 1'b0);

    // 5. amt=0, then amt=8 from DONE, then amt=2 from DONE (no idle bubble).
    step(3'd3, 8'hA5, 1'b0, '0,   1'b0, "load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    step(3'd7, 8'h00, 1'b0, 4'd0, 1'b0, "seq0",    8'hA5, 1'b0, 1'b0, 1'b1);
    step(3'd7, 8'h00, 1'b0, 4'd8, 1'b0, "seq8",    8'hA5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
           "seq8_step", seq8[i], 1'b0, (i != 7), (i == 7));
    step(3'd7, 8'h00, 1'b0, 4'd2, 1'b1, "seq2",    8'hA5, 1'b0, 1'b1, 1'b0);
    step(3'd0, 8'h00, 1'b0, '0,   1'b0, "seq2_s1", 8'h4B, 1'b0, 1'b1, 1'b0);
    step(3'd0, 8'h00, 1'b0, '0,   1'b0, "seq2_s2", 8'h96, 1'b0, 1'b0, 1'b1);
    step(3'd0, 8'h00, 1'b0, '0,   1'b0, "seq2_end", 8'h96, 1'b0, 1'b0, 1'b0);

    // 6. Abort an amt=5 sequence after its second step.
    step(3'd3, 8'h3C, 1'b0, '0,   1'b0, "load_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
    step(3'd7, 8'h00, 1'b0, 4'd5, 1'b1, "seq5",    8'h3C, 1'b0, 1'b1, 1'b0);
    step(3'd0, 8'h00, 1'b0, '0,   1'b0, "seq5_s1", 8'h78, 1'b0, 1'b1, 1'b0);
    step(3'd0, 8'h00, 1'b0, '0,   1'b0, "seq5_s2", 8'hF0, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 check_idle_reset("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++)
      step(3'd0, 8'h00, 1'b0, '0, 1'b0, "post_abort", 8'h00, 1'b0, 1'b0, 1'b0);

    // Random single-cycle opcodes against the behavioural model.
    m_q = '0;
    m_ser = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rc = 3'($urandom_range(0, 6));
      rd = 8'($urandom);
      rs = 1'($urandom);
      nq = m_q;
      nser = m_ser;
      case (rc)
        3'd1: begin nq = (m_q >> 1) | (rs ? 8'h80 : 8'h00); nser = m_q[0]; end
        3'd2: begin nq = (m_q << 1) | {7'd0, rs};            nser = m_q[7]; end
        3'd3: nq = rd;
        3'd4: nq = (m_q >> 1) | (m_q << 7);
        3'd5: nq = (m_q << 1) | (m_q >> 7);
        3'd6: begin nq = (m_q >> 1) | (m_q & 8'h80);          nser = m_q[0]; end
        default: ;
      endcase
      m_q = nq;
      m_ser = nser;
      step(rc, rd, rs, 4'($urandom), 1'($urandom), "random", m_q, m_ser, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
